instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of the control unit. Owns PC, MAR and the 24-bit instruction register.
//  Executes the control unit's PC_load/PC_en/PC_inc/MAR_load/IR_load strobes.
//  Fetches one 3-byte instruction over a byte-wide req/ack memory read port.
//  Presents it as command_word: opcode [23:16], operand A [15:8], operand B [7:0].
// PARAMETERS
//  PC_RESET        8'h00  PC value after reset
//  PC_STEP         3      bytes added to PC per PC_inc (one instruction)
//  TIMEOUT_CYCLES  15     max cycles waiting for mem_rd_ack per byte (FETCH_TIMEOUT_EN only)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  PC_load      in   8   jump/return target
//  PC_en        in   1   PC <= PC_load this edge
//  PC_inc       in   1   PC <= PC + PC_STEP this edge
//  MAR_load     in   1   MAR <= PC this edge
//  IR_load      in   1   start a 3-byte fetch from MAR
//  mem_addr     out  8   byte address of current read
//  mem_rd_req   out  1   read request, held until ack
//  mem_rd_ack   in   1   read data valid; may be combinational in same cycle as req
//  mem_rd_data  in   8   read byte, sampled when req && ack
//  command_word out  24  last completed instruction
//  ir_valid     out  1   1-cycle pulse when command_word updates
//  fetch_busy   out  1   fetch FSM not IDLE
//  pc_value     out  8   current PC
//  fetch_err    out  1   sticky timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (rst=0, async): PC=PC_RESET, MAR=0, command_word=0, ir_valid=0, mem_rd_req=0,
//   mem_addr=0, fetch_busy=0, fetch_err=0, FSM=IDLE. Mid-fetch reset aborts and discards bytes.
//  PC: PC_en has priority over PC_inc. Arithmetic is 8-bit mod 256 (8'hFE+3 -> 8'h01).
//  MAR_load copies pre-update PC. Same-edge PC_inc and MAR_load: MAR gets old PC.
//  FSM states: IDLE -> BYTE0 -> BYTE1 -> BYTE2 -> COMMIT -> IDLE.
//   IDLE: IR_load=1 -> BYTE0. IR_load is ignored in any other state (no queueing).
//   BYTEn: mem_rd_req=1, mem_addr=MAR+n (mod 256).
//    On req && ack, capture mem_rd_data into byte n and advance. No ack: stay.
//   COMMIT: command_word <= {b0,b1,b2} atomically; ir_valid=1; mem_rd_req=0; -> IDLE.
//  command_word is never partially updated; it holds its old value during a fetch.
//  Registered outputs. IR_load sampled at edge k: req high from cycle k+1.
//   Zero-wait memory: ir_valid in cycle k+4. Each extra wait cycle adds 1.
//  fetch_busy=1 in BYTE0..COMMIT.
//  MAR changes during a fetch do not affect the in-flight fetch; address offsets are
//   latched at BYTE0 entry.
//  PC_en/PC_inc during a fetch update PC normally and do not abort the fetch.
// CONFIGURATION
//  `define FETCH_TIMEOUT_EN: per-byte wait counter resets on entering each BYTEn.
//   If it reaches TIMEOUT_CYCLES without ack: drop req and return to IDLE.
//   On that abort: command_word <= 24'h0 (NOP), ir_valid pulses 1 cycle, fetch_err <= 1.
//   fetch_err clears only on reset.
//  Without it: no counter; BYTEn waits indefinitely; fetch_err tied 0.
// TESTING
//  1. Reset with PC_RESET=0, MAR_load, IR_load; memory[0..2]=01,02,2A with zero-wait.
//     Expect command_word=24'h01022A at k+4, ir_valid 1 cycle, mem_addr 0,1,2.
//  2. PC=8'hFE, PC_inc -> pc_value 8'h01. MAR=8'hFE fetch reads addrs FE,FF,00.
//  3. Same-edge PC_en=1 (PC_load=8'h40) and PC_inc=1 -> PC=8'h40.
//     Same-edge MAR_load and PC_inc from PC=3 -> MAR=3, PC=6.
//  4. Ack delayed 2 cycles on byte1: req held, mem_addr stable, ir_valid at k+6.
//     IR_load pulsed mid-fetch is ignored; old command_word held until COMMIT.
//  5. rst=0 asserted during BYTE1: req drops immediately, command_word=0, FSM IDLE.
//     Next fetch is correct.
//  6. FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack: req drops after 15 cycles.
//     command_word=0, ir_valid pulse, fetch_err=1 held. Without the macro: req stays high.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Byte-wide req/ack memory read port used by the instruction fetch unit.
interface instr_fetch_unit_if;
   logic [7:0] mem_addr;
   logic       mem_rd_req;
   logic       mem_rd_ack;
   logic [7:0] mem_rd_data;

   modport master (
      output mem_addr,
      output mem_rd_req,
      input  mem_rd_ack,
      input  mem_rd_data
   );

   modport slave (
      input  mem_addr,
      input  mem_rd_req,
      output mem_rd_ack,
      output mem_rd_data
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC/MAR registers and a 3-byte req/ack fetch into command_word.
// Define FETCH_TIMEOUT_EN to add a per-byte ack timeout that commits a NOP and sets fetch_err.
module instr_fetch_unit #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter logic [7:0] PC_STEP  = 8'd3
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 15
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         PC_load,
   input  logic               PC_en,
   input  logic               PC_inc,
   input  logic               MAR_load,
   input  logic               IR_load,
   instr_fetch_unit_if.master mem,
   output logic [23:0]        command_word,
   output logic               ir_valid,
   output logic               fetch_busy,
   output logic [7:0]         pc_value,
   output logic               fetch_err
);

   typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, COMMIT} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  pc_reg, mar_reg;
   logic [7:0]  base_reg, base_next;
   logic [7:0]  addr_reg, addr_next;
   logic [7:0]  b0_reg, b1_reg;
   logic [23:0] cw_reg;
   logic        req_reg, irv_reg, busy_reg;
   logic        capture, abort;

   // PC_en wins over PC_inc; MAR always receives the pre-update PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg  <= PC_RESET;
         mar_reg <= 8'h00;
      end else begin
         if (PC_en)
            pc_reg <= PC_load;
         else if (PC_inc)
            pc_reg <= pc_reg + PC_STEP;
         if (MAR_load)
            mar_reg <= pc_reg;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_reg;
   logic              err_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_reg <= '0;
         err_reg  <= 1'b0;
      end else begin
         if (state_next != state_reg)
            wait_reg <= '0;
         else if (req_reg)
            wait_reg <= wait_reg + WAIT_W'(1);
         if (abort)
            err_reg <= 1'b1;
      end
   end

   assign fetch_err = err_reg;
`else
   assign fetch_err = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      abort      = 1'b0;
      unique case (state_reg)
         IDLE: if (IR_load) state_next = BYTE0;
         BYTE0, BYTE1, BYTE2: begin
            if (mem.mem_rd_req && mem.mem_rd_ack) begin
               capture    = 1'b1;
               state_next = (state_reg == BYTE0) ? BYTE1 :
                            (state_reg == BYTE1) ? BYTE2 : COMMIT;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wait_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
`endif
         end
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // The base address is frozen when the fetch starts, so later MAR loads cannot disturb it.
      base_next = (state_reg == IDLE) ? mar_reg : base_reg;
      case (state_next)
         BYTE0:   addr_next = base_next;
         BYTE1:   addr_next = base_next + 8'd1;
         BYTE2:   addr_next = base_next + 8'd2;
         default: addr_next = addr_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         base_reg  <= 8'h00;
         addr_reg  <= 8'h00;
         b0_reg    <= 8'h00;
         b1_reg    <= 8'h00;
         cw_reg    <= 24'h0;
         req_reg   <= 1'b0;
         irv_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         base_reg  <= base_next;
         addr_reg  <= addr_next;
         req_reg   <= (state_next == BYTE0) || (state_next == BYTE1) || (state_next == BYTE2);
         busy_reg  <= (state_next != IDLE);
         irv_reg   <= (state_next == COMMIT) || abort;
         if (capture && state_reg == BYTE0)
            b0_reg <= mem.mem_rd_data;
         if (capture && state_reg == BYTE1)
            b1_reg <= mem.mem_rd_data;
         // The last byte goes straight into command_word so it lands together with ir_valid.
         if (state_next == COMMIT)
            cw_reg <= {b0_reg, b1_reg, mem.mem_rd_data};
         else if (abort)
            cw_reg <= 24'h0;
      end
   end

   assign mem.mem_addr   = addr_reg;
   assign mem.mem_rd_req = req_reg;
   assign command_word   = cw_reg;
   assign ir_valid       = irv_reg;
   assign fetch_busy     = busy_reg;
   assign pc_value       = pc_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fetch-level model plus directed vectors.
module tb_instr_fetch_unit;

   localparam logic [7:0] PC_RESET = 8'h00;
   localparam int         TIMEOUT  = 15;
`ifdef FETCH_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  pc_load;
   logic        pc_en, pc_inc, mar_load, ir_load;
   logic [23:0] command_word;
   logic        ir_valid, fetch_busy, fetch_err;
   logic [7:0]  pc_value;

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch_unit_if bus();

   instr_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .PC_load      (pc_load),
      .PC_en        (pc_en),
      .PC_inc       (pc_inc),
      .MAR_load     (mar_load),
      .IR_load      (ir_load),
      .mem          (bus),
      .command_word (command_word),
      .ir_valid     (ir_valid),
      .fetch_busy   (fetch_busy),
      .pc_value     (pc_value),
      .fetch_err    (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: per-address contents and number of wait cycles before ack.
   logic [7:0] mem_arr [256];
   int         wait_tab [256];
   int         wcnt;

   always @(posedge clk or negedge rst) begin
      if (!rst)
         wcnt <= 0;
      else if (!bus.mem_rd_req || bus.mem_rd_ack)
         wcnt <= 0;
      else
         wcnt <= wcnt + 1;
   end

   assign bus.mem_rd_ack  = bus.mem_rd_req && (wcnt >= wait_tab[bus.mem_addr]);
   assign bus.mem_rd_data = mem_arr[bus.mem_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Model: edge index ec; a fetch launched at edge f_L spends (wait+1) cycles per byte.
   int          ec      = 0;
   logic [7:0]  m_pc    = PC_RESET;
   logic [7:0]  m_mar   = 8'h00;
   logic [7:0]  m_base  = 8'h00;
   logic [23:0] m_cw    = 24'h0;
   logic [23:0] m_word  = 24'h0;
   logic        m_err   = 1'b0;
   bit          f_act   = 1'b0;
   bit          f_abort = 1'b0;
   int          f_L     = 0;
   int          f_E     = 0;
   int          f_free  = 0;
   int          f_s [4];

   task automatic launch();
      logic [7:0] a;
      int         w;
      f_act   = 1'b1;
      f_abort = 1'b0;
      f_L     = ec;
      m_base  = m_mar;
      m_word  = 24'h0;
      f_s[0]  = 0;
      for (int n = 0; n < 3; n++) begin
         a      = m_mar + 8'(n);
         w      = wait_tab[a];
         m_word = {m_word[15:0], mem_arr[a]};
         if (TMO_EN && !f_abort && w >= TIMEOUT) begin
            f_abort = 1'b1;
            f_E     = ec + f_s[n] + TIMEOUT;
         end
         f_s[n+1] = f_s[n] + w + 1;
      end
      if (!f_abort)
         f_E = ec + f_s[3];
      f_free = f_abort ? f_E + 1 : f_E + 2;
   endtask

   task automatic model_step();
      if (!rst) begin
         m_pc   = PC_RESET;
         m_mar  = 8'h00;
         m_cw   = 24'h0;
         m_err  = 1'b0;
         f_act  = 1'b0;
         f_free = 0;
      end else begin
         ec++;
         if (f_act && ec == f_E) begin
            if (f_abort) begin
               m_cw  = 24'h0;
               m_err = 1'b1;
            end else begin
               m_cw = m_word;
            end
         end
         if (ir_load && ec >= f_free)
            launch();
         if (mar_load)
            m_mar = m_pc;
         if (pc_en)
            m_pc = pc_load;
         else if (pc_inc)
            m_pc = m_pc + 8'd3;
      end
   endtask

   always @(posedge clk or negedge rst) model_step();

   task automatic compare_cycle();
      bit         req_e, busy_e, irv_e;
      logic [7:0] addr_e;
      int         rel;
      req_e  = f_act && ec >= f_L && ec < f_E;
      busy_e = f_act && ec >= f_L && (f_abort ? ec < f_E : ec <= f_E);
      irv_e  = f_act && ec == f_E;
      check("pc_value", pc_value, m_pc);
      check("command_word", command_word, m_cw);
      check("ir_valid", ir_valid, irv_e);
      check("fetch_busy", fetch_busy, busy_e);
      check("mem_rd_req", bus.mem_rd_req, req_e);
      check("fetch_err", fetch_err, m_err);
      if (req_e) begin
         rel    = ec - f_L;
         addr_e = m_base;
         for (int n = 0; n < 2; n++)
            if (rel >= f_s[n+1])
               addr_e = m_base + 8'(n + 1);
         check("mem_addr", bus.mem_addr, addr_e);
      end
      if (ir_valid)
         $display("[TB] fetch t=%0t command_word=%06h fetch_err=%0b", $time, command_word, fetch_err);
   endtask

   always @(negedge clk) compare_cycle();

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic en, input logic inc, input logic mar, input logic ir,
                        input logic [7:0] load);
      pc_en    = en;
      pc_inc   = inc;
      mar_load = mar;
      ir_load  = ir;
      pc_load  = load;
      tick();
      pc_en    = 1'b0;
      pc_inc   = 1'b0;
      mar_load = 1'b0;
      ir_load  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      while ((fetch_busy || ir_valid) && i < 60) begin
         tick();
         i++;
      end
      check({name, "_bound"}, 32'(i < 60), 32'd1);
   endtask

   initial begin
      logic [7:0] exp_addr [3];
      rst      = 1'b0;
      pc_load  = 8'h00;
      pc_en    = 1'b0;
      pc_inc   = 1'b0;
      mar_load = 1'b0;
      ir_load  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i]  = 8'(i) ^ 8'h5A;
         wait_tab[i] = 0;
      end
      mem_arr[8'h00] = 8'h01; mem_arr[8'h01] = 8'h02; mem_arr[8'h02] = 8'h2A;
      mem_arr[8'hFE] = 8'hAA; mem_arr[8'hFF] = 8'hBB;
      mem_arr[8'h03] = 8'h11; mem_arr[8'h04] = 8'h22; mem_arr[8'h05] = 8'h33;
      mem_arr[8'h06] = 8'h5A; mem_arr[8'h07] = 8'h5B; mem_arr[8'h08] = 8'h5C;
      mem_arr[8'h20] = 8'hC1; mem_arr[8'h21] = 8'hC2; mem_arr[8'h22] = 8'hC3;
      wait_tab[8'h04] = 2;
      wait_tab[8'h07] = 3;
      wait_tab[8'h20] = 20;

      tick();
      tick();
      check("rst_pc", pc_value, 8'h00);
      check("rst_cw", command_word, 24'h0);
      check("rst_req", bus.mem_rd_req, 1'b0);
      check("rst_err", fetch_err, 1'b0);
      rst = 1'b1;
      tick();

      // Zero-wait fetch from address 0.
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("t1_a0", bus.mem_addr, 8'h00);
      tick();
      check("t1_a1", bus.mem_addr, 8'h01);
      tick();
      check("t1_a2", bus.mem_addr, 8'h02);
      tick();
      check("t1_irv", ir_valid, 1'b1);
      check("t1_cw", command_word, 24'h01022A);
      tick();
      check("t1_irv_drop", ir_valid, 1'b0);

      // PC wrap and a fetch that wraps the address space.
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("t2_pc_wrap", pc_value, 8'h01);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
      for (int n = 0; n < 3; n++) begin
         check("t2_addr", bus.mem_addr, exp_addr[n]);
         tick();
      end
      check("t2_cw", command_word, 24'hAABB01);
      tick();

      // PC_en priority, same-edge MAR_load/PC_inc.
      pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
      check("t3_pc_en_prio", pc_value, 8'h40);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
      pulse(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      check("t3_pc_inc", pc_value, 8'h06);

      // Fetch from MAR=3 with 2 wait cycles on byte1; mid-fetch IR_load and MAR_load ignored.
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("t4_a0", bus.mem_addr, 8'h03);
      pulse(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      check("t4_a1", bus.mem_addr, 8'h04);
      check("t4_cw_hold", command_word, 24'hAABB01);
      tick();
      check("t4_a1_w1", bus.mem_addr, 8'h04);
      tick();
      check("t4_a1_w2", bus.mem_addr, 8'h04);
      check("t4_req_held", bus.mem_rd_req, 1'b1);
      tick();
      check("t4_a2", bus.mem_addr, 8'h05);
      tick();
      check("t4_irv", ir_valid, 1'b1);
      check("t4_cw", command_word, 24'h112233);
      wait_idle("t4");

      // Reset during BYTE1 aborts the fetch; the next fetch is clean.
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("t5_a0", bus.mem_addr, 8'h06);
      tick();
      check("t5_a1", bus.mem_addr, 8'h07);
      rst = 1'b0;
      #1;
      check("t5_req_drop", bus.mem_rd_req, 1'b0);
      check("t5_cw_clr", command_word, 24'h0);
      check("t5_busy_clr", fetch_busy, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check("t5_pc_rst", pc_value, 8'h00);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      wait_idle("t5");
      check("t5_cw_refetch", command_word, 24'h01022A);

      // Memory that withholds ack on byte0 for 20 cycles.
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 1; i < TIMEOUT; i++) begin
         tick();
         check("t6_req_hold", bus.mem_rd_req, 1'b1);
      end
      tick();
`ifdef FETCH_TIMEOUT_EN
      check("t6_req_drop", bus.mem_rd_req, 1'b0);
      check("t6_irv", ir_valid, 1'b1);
      check("t6_cw_nop", command_word, 24'h0);
      check("t6_err", fetch_err, 1'b1);
      tick();
      check("t6_irv_drop", ir_valid, 1'b0);
      check("t6_err_sticky", fetch_err, 1'b1);
`else
      check("t6_req_still", bus.mem_rd_req, 1'b1);
      tick();
      check("t6_req_still2", bus.mem_rd_req, 1'b1);
      check("t6_err_tied", fetch_err, 1'b0);
      wait_idle("t6");
      check("t6_cw", command_word, 24'hC1C2C3);
`endif
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
